memoria_compartilhada_arb: RTL
==============================

# memoria_compartilhada_arb

Parametrised shared data memory for the multi-core MIPS build. It serves `N_PORTS` requesters through a round-robin arbiter with a req/ack handshake. It supports byte-enable writes, range checking, and optional LL/SC reservations. It sits between the per-core load/store stages and the common data store, and replaces the single-port unarbitrated memory.

## Interface
- `DATA_W`, 32: data word width; must be a multiple of 8.
- `DEPTH`, 512: number of words.
- `ADDR_W`, 32: byte-address width per port.
- `N_PORTS`, 2: number of requesters, 1..4.

Ports:
- `clock`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  N_PORTS: per-port request.
- `op`  in  2*N_PORTS: per-port operation; 00 read, 01 write, 10 LL, 11 SC.
- `endereco`  in  ADDR_W*N_PORTS: per-port byte address; word index = addr[ADDR_W-1:2]; bits [1:0] ignored.
- `indata`  in  DATA_W*N_PORTS: per-port write data.
- `be`  in  (DATA_W/8)*N_PORTS: per-port byte enables, writes/SC only.
- `ack`  out  N_PORTS: one-cycle completion pulse.
- `err`  out  N_PORTS: out-of-range flag, valid with `ack`.
- `output_mem`  out  DATA_W*N_PORTS: per-port read data, valid with `ack`, held until next ack on that port.

## Operation
- **Eligibility.** Port p is eligible when `req[p]`=1 and `ack[p]`=0 in the current cycle.
- **Arbiter.** Round-robin, one grant per cycle. Priority starts at `last+1` modulo N_PORTS. On a grant, `last` is updated to the granted port. If no port is eligible, `last` is unchanged.
- **Access.** The granted access executes at the edge where it is granted.
  - Read/LL: `output_mem[p]` <= mem[idx].
  - Write: each byte i with `be[i]`=1 is written. `output_mem[p]` <= 0.
  - `be`=0 on a write: ack is still returned, memory unchanged.
- **Range check.** If idx >= DEPTH: no memory change, `output_mem[p]` <= 0, `err[p]`=1 with the ack, reservations untouched.
- **Requester rule.** The requester holds `req`, `op`, `endereco`, `indata` and `be` stable until it samples `ack`=1. The ack cycle is never re-granted to that port, so a requester that keeps `req` high gets back-to-back accesses every 2 cycles.
- **Memory contents** are not reset.

## Timing
- Latency: a grant at edge k drives `ack`/`output_mem`/`err` high for the cycle after edge k, i.e. 1 cycle from request sampled to ack. With no contention, an access completes on the first edge.
- Contention: with all N ports requesting continuously, each port waits at most N-1 grant cycles.
- Reset values: `ack`=0, `err`=0, `output_mem`=0, `last`=N_PORTS-1 so port 0 wins first, all reservations cleared.
- Reset asserted at an edge takes priority: no grant, no memory write, pending acks dropped.
- Only one grant per cycle, so simultaneous same-address write collisions cannot occur.

## Configuration
- `MEMCOMP_LLSC_EN` defined:
  - Each port has a reservation valid bit and word index.
  - LL reads and sets the reservation for its port.
  - Any successful write or SC by any port to word W clears every reservation on W.
  - SC writes, returns `output_mem`=1, and clears its own reservation only if that reservation is valid and its index matches. Otherwise no write, `output_mem`=0.
  - An out-of-range LL/SC gets `err`=1 and does not touch reservations.
- `MEMCOMP_LLSC_EN` not defined: no reservation state. LL behaves as read; SC behaves as write and returns `output_mem`=1.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to byte addr 0x10 with `be`=1111, then reads it → ack one cycle after each request, read `output_mem`=0xDEADBEEF, `err`=0.
- Write 0x000000AA with `be`=0001 over 0xDEADBEEF, then read → 0xDEADBEAA.
- Ports 0 and 1 both hold `req` continuously for 8 cycles → grants alternate 0,1,0,1…; each port acks every 2 cycles; no port starves.
- Read addr 4*DEPTH → `ack`=1, `err`=1, `output_mem`=0; write to 4*DEPTH leaves all words unchanged.
- Reset asserted in the same cycle as a write request → no ack follows; later read shows old data; next grant goes to port 0.
- With `MEMCOMP_LLSC_EN`: port 0 LL 0x20, port 1 writes 0x20, port 0 SC 0x20 → SC `output_mem`=0, memory holds port 1 data. Repeat without the intervening write → `output_mem`=1 and data is written.

Source files
------------

// File: rtl/memoria_compartilhada_arb_if.sv
// Request/acknowledge bus between the per-core load/store stages and the
// shared data memory; one flattened lane per requester.
interface memoria_compartilhada_arb_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int N_PORTS = 2
);
  logic [N_PORTS-1:0]            req;
  logic [2*N_PORTS-1:0]          op;
  logic [ADDR_W*N_PORTS-1:0]     endereco;
  logic [DATA_W*N_PORTS-1:0]     indata;
  logic [(DATA_W/8)*N_PORTS-1:0] be;
  logic [N_PORTS-1:0]            ack;
  logic [N_PORTS-1:0]            err;
  logic [DATA_W*N_PORTS-1:0]     output_mem;

  modport master (output req, op, endereco, indata, be, input ack, err, output_mem);
  modport slave  (input req, op, endereco, indata, be, output ack, err, output_mem);
endinterface

// File: rtl/memoria_compartilhada_arb.sv
// Shared data memory with round-robin arbitration over N_PORTS requesters.
// Optional LL/SC reservations are enabled with `define MEMCOMP_LLSC_EN.
module memoria_compartilhada_arb #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = 32,
  parameter int N_PORTS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  memoria_compartilhada_arb_if.slave bus
);
  localparam int NB = DATA_W / 8;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0]         r_mem [DEPTH];
  logic [PW-1:0]             r_last;
  logic [N_PORTS-1:0]        r_ack;
  logic [N_PORTS-1:0]        r_err;
  logic [DATA_W*N_PORTS-1:0] r_out;

  logic              w_gnt;
  logic [PW-1:0]     w_gp;
  logic [1:0]        w_op;
  logic [ADDR_W-1:0] w_word;
  logic [DATA_W-1:0] w_wdata;
  logic [NB-1:0]     w_be;
  logic              w_inrange;
  logic [IW-1:0]     w_idx;
  logic              w_sc_ok;
  logic              w_wr;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_result;

  // Round-robin pick: descending scan so the port closest after r_last wins.
  always_comb begin
    w_gnt = 1'b0;
    w_gp  = r_last;
    for (int k = N_PORTS; k >= 1; k--) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (((int'(r_last) + k) % N_PORTS) == p && bus.req[p] && !r_ack[p]) begin
          w_gnt = 1'b1;
          w_gp  = PW'(p);
        end else begin
          w_gnt = w_gnt;
        end
      end
    end
  end

  // Route the granted port's request fields.
  always_comb begin
    w_op    = 2'b00;
    w_word  = {ADDR_W{1'b0}};
    w_wdata = {DATA_W{1'b0}};
    w_be    = {NB{1'b0}};
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_gp == PW'(p)) begin
        w_op    = bus.op[2*p +: 2];
        w_word  = {2'b00, bus.endereco[ADDR_W*p+2 +: ADDR_W-2]};
        w_wdata = bus.indata[DATA_W*p +: DATA_W];
        w_be    = bus.be[NB*p +: NB];
      end else begin
        w_op = w_op;
      end
    end
  end

  assign w_inrange = (w_word < DEPTH_A);
  assign w_idx     = w_word[IW-1:0];
  assign w_rdata   = r_mem[w_idx];

`ifdef MEMCOMP_LLSC_EN
  logic [N_PORTS-1:0] r_rsv_v;
  logic [IW-1:0]      r_rsv_idx [N_PORTS];

  // SC succeeds only against the granted port's own live reservation.
  always_comb begin
    w_sc_ok = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_gp == PW'(p)) begin
        w_sc_ok = r_rsv_v[p] && (r_rsv_idx[p] == w_idx);
      end else begin
        w_sc_ok = w_sc_ok;
      end
    end
  end

  // Reservation tracking; any store to a word kills every reservation on it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rsv_v <= {N_PORTS{1'b0}};
    end else if (w_gnt && w_inrange) begin
      for (int p = 0; p < N_PORTS; p++) begin
        if (w_wr && r_rsv_v[p] && (r_rsv_idx[p] == w_idx)) begin
          r_rsv_v[p] <= 1'b0;
        end
        if ((w_gp == PW'(p)) && (w_op == 2'b10)) begin
          r_rsv_v[p]   <= 1'b1;
          r_rsv_idx[p] <= w_idx;
        end
      end
    end
  end
`else
  assign w_sc_ok = 1'b1;
`endif

  assign w_wr = w_gnt && w_inrange &&
                ((w_op == 2'b01) || ((w_op == 2'b11) && w_sc_ok));

  // Value returned to the requester with its ack.
  always_comb begin
    w_result = {DATA_W{1'b0}};
    if (w_inrange) begin
      case (w_op)
        2'b00, 2'b10: w_result = w_rdata;
        2'b11:        w_result = {{(DATA_W-1){1'b0}}, w_sc_ok};
        default:      w_result = {DATA_W{1'b0}};
      endcase
    end else begin
      w_result = {DATA_W{1'b0}};
    end
  end

  // Arbiter pointer and per-port response registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= PW'(N_PORTS - 1);
      r_ack  <= {N_PORTS{1'b0}};
      r_err  <= {N_PORTS{1'b0}};
      r_out  <= {(DATA_W*N_PORTS){1'b0}};
    end else begin
      r_ack <= {N_PORTS{1'b0}};
      r_err <= {N_PORTS{1'b0}};
      if (w_gnt) begin
        r_last <= w_gp;
        for (int p = 0; p < N_PORTS; p++) begin
          if (w_gp == PW'(p)) begin
            r_ack[p]                   <= 1'b1;
            r_err[p]                   <= !w_inrange;
            r_out[DATA_W*p +: DATA_W] <= w_result;
          end
        end
      end
    end
  end

  // Byte-lane writes; contents are deliberately left unreset.
  always_ff @(posedge clock) begin
    if (!reset && w_wr) begin
      for (int i = 0; i < NB; i++) begin
        if (w_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
        end
      end
    end
  end

  assign bus.ack        = r_ack;
  assign bus.err        = r_err;
  assign bus.output_mem = r_out;
endmodule
